// File: rtl/fifo_stream_pkg.sv
// fifo_stream_pkg: shared default width, data type and counter-width helper
package fifo_stream_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef logic [DEFAULT_WIDTH-1:0] data_t;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_stream_if.sv
// fifo_stream_if: valid/ready/data stream bundle with producer and consumer views
interface fifo_stream_if import fifo_stream_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] data;
  logic valid;
  logic ready;
  modport master (output data, output valid, input ready);
  modport slave (input data, input valid, output ready);
endinterface

// File: rtl/fifo_stream_fifo.sv
// fifo_stream_fifo: circular buffer followed by a registered output stage
module fifo_stream_fifo import fifo_stream_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 8
) (
  input logic clk_i,
  input logic rstn_i,
  fifo_stream_if.slave s,
  fifo_stream_if.master m
);
  localparam int PW = cw(DEPTH);
  localparam int CW = cw(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d, wr, rd, adv;
  assign s.ready = count_q < CW'(DEPTH);
  always_comb begin
    wr = s.valid && s.ready;
    adv = !valid_q || m.ready;
    rd = adv && count_q != '0;
    wr_d = wr ? wr_q + 1'b1 : wr_q;
    rd_d = rd ? rd_q + 1'b1 : rd_q;
    count_d = count_q + CW'(wr) - CW'(rd);
    data_d = rd ? mem_q[rd_q] : data_q;
    valid_d = adv ? rd : valid_q;
  end
  always_ff @(posedge clk_i) begin
    wr_q <= rstn_i ? wr_d : '0;
    rd_q <= rstn_i ? rd_d : '0;
    count_q <= rstn_i ? count_d : '0;
    data_q <= rstn_i ? data_d : '0;
    valid_q <= rstn_i ? valid_d : 1'b0;
  end
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wr_q] <= s.data;
  end
  assign m.data = data_q;
  assign m.valid = valid_q;
endmodule

// File: rtl/fifo_stream_sink.sv
// fifo_stream_sink: consumer that waits DELAYSINK cycles of valid input before accepting
module fifo_stream_sink import fifo_stream_pkg::*; #(
  parameter int DELAYSINK = 0
) (
  input logic clk_i,
  input logic rstn_i,
  fifo_stream_if.slave s
);
  localparam int WW = cw(DELAYSINK + 1);
  logic [WW-1:0] w_q, w_d;
  logic at_max;
  always_comb begin
    at_max = w_q == WW'(DELAYSINK);
    s.ready = s.valid && at_max;
    w_d = s.ready ? '0 : (s.valid && !at_max) ? w_q + 1'b1 : w_q;
  end
  always_ff @(posedge clk_i) begin
    w_q <= rstn_i ? w_d : '0;
  end
endmodule

// File: rtl/fifo_stream_source.sv
// fifo_stream_source: counting word generator with an optional idle gap after each transfer
module fifo_stream_source import fifo_stream_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DELAYSOURCE = 0
) (
  input logic clk_i,
  input logic rstn_i,
  fifo_stream_if.master m
);
  localparam int GW = cw(DELAYSOURCE + 1);
  logic [WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d, xfer;
  logic [GW-1:0] gap_q, gap_d, gap_dec;
  always_comb begin
    xfer = valid_q && m.ready;
    gap_dec = gap_q != '0 ? gap_q - 1'b1 : gap_q;
    data_d = data_q;
    valid_d = valid_q;
    gap_d = gap_dec;
    if (xfer && DELAYSOURCE > 0) begin
      valid_d = 1'b0;
      gap_d = GW'(DELAYSOURCE);
    end else if ((!valid_q || xfer) && gap_dec == '0) begin
      valid_d = 1'b1;
      data_d = data_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    data_q <= rstn_i ? data_d : '0;
    valid_q <= rstn_i ? valid_d : 1'b0;
    gap_q <= rstn_i ? gap_d : '0;
  end
  assign m.data = data_q;
  assign m.valid = valid_q;
endmodule

// File: rtl/fifo_stream_top.sv
// fifo_stream_top: source -> fifo -> sink pipeline exposing the fifo output stream and handshakes
module fifo_stream_top import fifo_stream_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 8,
  parameter int DELAYSOURCE = 0,
  parameter int DELAYSINK = 0
) (
  input logic clk_i,
  input logic rstn_i,
  output logic [WIDTH-1:0] data_o,
  output logic valid_o,
  output logic sink_ready_o,
  output logic fifo_ready_o,
  output logic src_valid_o
);
  fifo_stream_if #(.WIDTH(WIDTH)) src_s ();
  fifo_stream_if #(.WIDTH(WIDTH)) out_s ();
  fifo_stream_source #(.WIDTH(WIDTH), .DELAYSOURCE(DELAYSOURCE)) u_src (
    .clk_i(clk_i), .rstn_i(rstn_i), .m(src_s)
  );
  fifo_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk_i(clk_i), .rstn_i(rstn_i), .s(src_s), .m(out_s)
  );
  fifo_stream_sink #(.DELAYSINK(DELAYSINK)) u_sink (
    .clk_i(clk_i), .rstn_i(rstn_i), .s(out_s)
  );
  assign data_o = out_s.data;
  assign valid_o = out_s.valid;
  assign sink_ready_o = out_s.ready;
  assign fifo_ready_o = src_s.ready;
  assign src_valid_o = src_s.valid;
endmodule

// File: tb/tb_fifo_stream_top.sv
// tb_fifo_stream_top: four pipeline configurations checked by directed probes and per-stream scoreboards
module tb_fifo_stream_top;
  import fifo_stream_pkg::*;
  localparam int PER [4] = '{1, 3, 6, 4};
  localparam int MIN_XFERS [4] = '{300, 100, 50, 80};
  logic clk;
  logic rstn [4];
  data_t d [4];
  logic v [4], sr [4], fr [4], sv [4];
  data_t exp_q [4][$];
  int compared = 0;
  int mism = 0;
  int cyc = 0;
  int last [4];
  int xfers [4];
  logic seen [4];
  logic prev_out_hold [4], prev_src_hold [4];
  data_t prev_d [4];
  fifo_stream_if #(.WIDTH(8)) obs_if ();
  assign obs_if.data = d[0];
  assign obs_if.valid = v[0];
  assign obs_if.ready = sr[0];
  fifo_stream_top #(.DEPTH(8), .DELAYSOURCE(0), .DELAYSINK(0)) u0 (
    .clk_i(clk), .rstn_i(rstn[0]), .data_o(d[0]), .valid_o(v[0]),
    .sink_ready_o(sr[0]), .fifo_ready_o(fr[0]), .src_valid_o(sv[0])
  );
  fifo_stream_top #(.DEPTH(8), .DELAYSOURCE(0), .DELAYSINK(2)) u1 (
    .clk_i(clk), .rstn_i(rstn[1]), .data_o(d[1]), .valid_o(v[1]),
    .sink_ready_o(sr[1]), .fifo_ready_o(fr[1]), .src_valid_o(sv[1])
  );
  fifo_stream_top #(.DEPTH(4), .DELAYSOURCE(0), .DELAYSINK(5)) u2 (
    .clk_i(clk), .rstn_i(rstn[2]), .data_o(d[2]), .valid_o(v[2]),
    .sink_ready_o(sr[2]), .fifo_ready_o(fr[2]), .src_valid_o(sv[2])
  );
  fifo_stream_top #(.DEPTH(8), .DELAYSOURCE(3), .DELAYSINK(0)) u3 (
    .clk_i(clk), .rstn_i(rstn[3]), .data_o(d[3]), .valid_o(v[3]),
    .sink_ready_o(sr[3]), .fifo_ready_o(fr[3]), .src_valid_o(sv[3])
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rstn[i] && prev_out_hold[i]) begin
        check($sformatf("u%0d_valid_hold", i), v[i], 1);
        check($sformatf("u%0d_data_hold", i), d[i], prev_d[i]);
      end
      if (rstn[i] && prev_src_hold[i]) check($sformatf("u%0d_src_hold", i), sv[i], 1);
      if (rstn[i] && v[i] && sr[i]) begin
        if (exp_q[i].size() == 0) begin
          compared++;
          mism++;
          $display("FAIL sb%0d: got %0d expected nothing (queue empty)", i, d[i]);
        end else begin
          check($sformatf("sb%0d", i), d[i], exp_q[i].pop_front());
        end
        if (seen[i]) check($sformatf("u%0d_spacing", i), cyc - last[i], PER[i]);
        seen[i] = 1'b1;
        last[i] = cyc;
        xfers[i]++;
      end
      prev_out_hold[i] = rstn[i] && v[i] && !sr[i];
      prev_src_hold[i] = rstn[i] && sv[i] && !fr[i];
      prev_d[i] = d[i];
    end
  end
  initial begin
    logic found;
    for (int i = 0; i < 4; i++) begin
      rstn[i] = 1'b0;
      seen[i] = 1'b0;
      xfers[i] = 0;
      last[i] = 0;
      prev_out_hold[i] = 1'b0;
      prev_src_hold[i] = 1'b0;
    end
    step(3);
    check("rst_data", obs_if.data, 0);
    check("rst_valid", obs_if.valid, 0);
    check("rst_sink_ready", obs_if.ready, 0);
    check("rst_fifo_ready", fr[0], 1);
    check("rst_src_valid", sv[0], 0);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 400; k++) exp_q[i].push_back(data_t'(k + 1));
    for (int i = 0; i < 4; i++) rstn[i] = 1'b1;
    step(1);
    check("e1_u0_src_valid", sv[0], 1);
    check("e1_u0_valid", v[0], 0);
    check("e1_u3_src_valid", sv[3], 1);
    step(1);
    check("e2_u0_valid", v[0], 0);
    check("e2_u3_src_valid", sv[3], 0);
    step(1);
    check("e3_u0_valid", v[0], 1);
    check("e3_u0_data", d[0], 1);
    check("e3_u1_data", d[1], 1);
    check("e3_u2_data", d[2], 1);
    check("e3_u3_valid", v[3], 1);
    check("e3_u3_data", d[3], 1);
    step(1);
    check("e4_u0_data", d[0], 2);
    check("e4_u3_valid", v[3], 0);
    step(1);
    check("e5_u2_fifo_ready", fr[2], 1);
    check("e5_u3_src_valid", sv[3], 1);
    step(1);
    check("e6_u1_data", d[1], 2);
    check("e6_u2_fifo_ready", fr[2], 0);
    check("e6_u2_src_valid", sv[2], 1);
    step(1);
    check("e7_u3_valid", v[3], 1);
    check("e7_u3_data", d[3], 2);
    step(2);
    check("e9_u1_data", d[1], 3);
    step(3);
    check("e12_u1_fifo_ready", fr[1], 1);
    step(1);
    check("e13_u1_fifo_ready", fr[1], 0);
    found = 1'b0;
    for (int k = 0; k < 700 && !found; k++) begin
      @(negedge clk);
      if (xfers[0] > 256 && v[0] && d[0] == 8'd40) found = 1'b1;
    end
    check("u0_wrap_reach_40", found, 1);
    rstn[0] = 1'b0;
    step(1);
    check("midrst_data", d[0], 0);
    check("midrst_valid", v[0], 0);
    exp_q[0].delete();
    seen[0] = 1'b0;
    for (int k = 0; k < 100; k++) exp_q[0].push_back(data_t'(k + 1));
    rstn[0] = 1'b1;
    step(2);
    check("restart_e2_valid", v[0], 0);
    step(1);
    check("restart_e3_valid", v[0], 1);
    check("restart_e3_data", d[0], 1);
    step(60);
    for (int i = 0; i < 4; i++) check($sformatf("u%0d_progress", i), int'(xfers[i] >= MIN_XFERS[i]), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
